// File: rtl/regfile_write_arbiter_if.sv
// Bundles the WB, aux, scoreboard and register-file write signals of the write-port arbiter.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_reg;
  logic [31:0] aux_data;
  logic        alloc_we;
  logic [4:0]  alloc_reg;
  logic [31:0] pending;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  modport slave (
    input  wb_we, wb_reg, wb_data,
    input  aux_valid, aux_reg, aux_data,
    input  alloc_we, alloc_reg,
    output aux_ready, pending, wb_stall,
    output RegWrite, WriteReg, WriteData
  );

  modport master (
    output wb_we, wb_reg, wb_data,
    output aux_valid, aux_reg, aux_data,
    output alloc_we, alloc_reg,
    input  aux_ready, pending, wb_stall,
    input  RegWrite, WriteReg, WriteData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between priority WB writes and a buffered aux result FIFO,
// with a pending-write scoreboard, WAW squash of stale aux entries and anti-starvation stalls.
module regfile_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            fifo_reg_q  [FIFO_DEPTH];
  logic [4:0]            fifo_reg_d  [FIFO_DEPTH];
  logic [31:0]           fifo_data_q [FIFO_DEPTH];
  logic [31:0]           fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic [31:0]           pending_q, pending_d;
  logic                  regwrite_q, regwrite_d;
  logic [4:0]            write_reg_q, write_reg_d;
  logic [31:0]           write_data_q, write_data_d;

  logic aux_ready;
  logic nonempty, head_vld, wb_eff, pop, push;

  assign aux_ready     = (count_q != CW'(FIFO_DEPTH));
  assign bus.aux_ready = aux_ready;
  assign bus.pending   = pending_q;
  assign bus.wb_stall  = stall_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.WriteReg  = write_reg_q;
  assign bus.WriteData = write_data_q;

  always_comb begin
    fifo_reg_d   = fifo_reg_q;
    fifo_data_d  = fifo_data_q;
    vld_d        = vld_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    starve_d     = starve_q;
    stall_d      = 1'b0;
    pending_d    = pending_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    nonempty = (count_q != '0);
    head_vld = nonempty && vld_q[rd_ptr_q];
    wb_eff   = bus.wb_we && (bus.wb_reg != '0) && !stall_q;
    pop      = nonempty && (stall_q || !wb_eff);
    push     = bus.aux_valid && aux_ready && (bus.aux_reg != '0);

    if (wb_eff) begin
      regwrite_d   = 1'b1;
      write_reg_d  = bus.wb_reg;
      write_data_d = bus.wb_data;
    end else if (pop && head_vld) begin
      regwrite_d   = 1'b1;
      write_reg_d  = fifo_reg_q[rd_ptr_q];
      write_data_d = fifo_data_q[rd_ptr_q];
      pending_d[fifo_reg_q[rd_ptr_q]] = 1'b0;
    end

    // Squash only looks at stored entries; the push below lands after it.
    if (wb_eff) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (vld_q[i] && (fifo_reg_q[i] == bus.wb_reg)) begin
          vld_d[i] = 1'b0;
          pending_d[fifo_reg_q[i]] = 1'b0;
        end
      end
    end

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q]       = 1'b1;
      fifo_reg_d[wr_ptr_q]  = bus.aux_reg;
      fifo_data_d[wr_ptr_q] = bus.aux_data;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.alloc_we && (bus.alloc_reg != '0)) pending_d[bus.alloc_reg] = 1'b1;
    pending_d[0] = 1'b0;

    if (pop || (count_d == '0)) begin
      starve_d = '0;
    end else if (wb_eff && head_vld) begin
      starve_d = starve_q + SW'(1);
    end
    if (starve_d == SW'(STARVE_LIMIT)) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_reg_q   <= '{default: '0};
      fifo_data_q  <= '{default: '0};
      vld_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      stall_q      <= 1'b0;
      pending_q    <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      fifo_reg_q   <= fifo_reg_d;
      fifo_data_q  <= fifo_data_d;
      vld_q        <= vld_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      stall_q      <= stall_d;
      pending_q    <= pending_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 MIPS register file between two sources.
- Source 1 is the pipeline writeback stage (WB). It has priority and carries no backpressure.
- Source 2 is a multi-cycle auxiliary unit (mult/div) that returns results through a valid/ready handshake into a small FIFO.
- The block keeps a pending-write scoreboard so issue logic can stall on RAW hazards against in-flight aux results, and it enforces fairness so aux results cannot starve.

Parameters:
- FIFO_DEPTH, 2, number of aux result entries buffered (power of 2, at least 2).
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before WB is stalled (at least 1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wb_we  input  1  WB write request this cycle.
- wb_reg  input  5  WB destination register.
- wb_data  input  32  WB write data.
- aux_valid  input  1  aux result offered.
- aux_ready  output  1  FIFO can accept; high when the FIFO is not full.
- aux_reg  input  5  aux destination register.
- aux_data  input  32  aux result data.
- alloc_we  input  1  multi-cycle op issued; mark its destination pending.
- alloc_reg  input  5  destination of the issued op.
- pending  output  32  bit i=1 means register i awaits an aux result; bit 0 is always 0.
- wb_stall  output  1  WB must hold and replay its write next cycle.
- RegWrite  output  1  register-file write enable.
- WriteReg  output  5  register-file write address.
- WriteData  output  32  register-file write data.

Behaviour:
- Clocking and reset
  - Single clock. Reset is synchronous and active-high.
  - On reset: FIFO empty, starvation counter 0, pending=0, wb_stall=0, RegWrite=0, WriteReg=0, WriteData=0.
  - Reset mid-operation discards all buffered aux entries.
- Output timing
  - RegWrite, WriteReg and WriteData are registered.
  - A write selected in cycle N appears on the outputs in cycle N+1 and lands in the register file at the end of N+1. Latency is 1 cycle.
  - RegWrite=0 in every cycle with no selected write. WriteReg and WriteData then hold their previous values.
- WB effective
  - wb_eff = wb_we and wb_reg!=0 and not wb_stall.
  - WB writes to r0 never produce RegWrite.
- Arbitration each cycle (evaluated in this order)
  1. If wb_stall=1: commit the FIFO head if the FIFO is non-empty. WB inputs are ignored; the pipeline replays them.
  2. Else if wb_eff: commit WB.
  3. Else if the FIFO is non-empty: commit the FIFO head (pop).
  4. Else: no write.
- Aux acceptance
  - A transfer occurs when aux_valid and aux_ready.
  - aux_reg=0: the transfer completes but nothing is enqueued.
  - Otherwise the entry is enqueued at the tail after the squash check below, so same-cycle arrivals are never squashed.
  - Simultaneous pop and push in the same cycle is legal when full; aux_ready is nonetheless computed from the registered count (no full-to-ready bypass).
- WAW squash
  - When wb_eff commits register R, every stored FIFO entry whose destination is R is invalidated; the newer WB value wins.
  - An invalidated entry still occupies its slot. On reaching the head it is popped with RegWrite=0 and costs one cycle.
- Starvation counter
  - Increments when the FIFO holds a valid head and WB wins arbitration.
  - Clears on any aux commit or when the FIFO becomes empty.
  - When the counter reaches STARVE_LIMIT, wb_stall is asserted (registered) for exactly one cycle, then the counter clears.
- Scoreboard
  - pending[alloc_reg] is set on alloc_we when alloc_reg!=0.
  - pending[R] is cleared when an aux write to R commits or when an entry for R is squashed.
  - Set has priority over clear for the same register in the same cycle.
  - pending[0] is hard-wired to 0.
- Wrap-around
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - The count distinguishes full from empty.

Test Plan:
- Reset, then idle: RegWrite=0, pending=0, aux_ready=1, wb_stall=0 for 5 cycles.
- WB alone: wb_we=1, wb_reg=5, wb_data=0xDEADBEEF in cycle N -> RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in N+1. Same stimulus with wb_reg=0 -> RegWrite=0.
- Collision: alloc r7; aux r7=0x11 and WB r3=0x22 in the same cycle -> r3 written first, r7 one cycle later, then pending[7]=0.
- WAW squash: aux r9=0xAA buffered; WB r9=0xBB while the FIFO head is stalled -> only 0xBB written to r9, the squashed slot pops with RegWrite=0, pending[9]=0.
- Full and starvation: fill the FIFO (aux_ready=0) and hold wb_we=1 continuously -> after 4 lost cycles wb_stall=1 for one cycle, the head commits, and aux_ready returns to 1.
- Reset mid-operation with 2 entries buffered -> FIFO empty, pending=0, no further RegWrite.
